// File: rtl/bsg_link_upstream_sched_pkg.sv
// Shared types and helpers for the upstream link scheduler.
package bsg_link_sched_pkg;

  // Scheduler state: IDLE arbitrates freely, BUSY is locked to one requester
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

  // Bits needed to hold a credit count from 0 up to and including credits
  function automatic int count_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/bsg_link_upstream_sched_if.sv
// Requester-side and link-side handshake bundle for the upstream scheduler.
// The master side is the environment (requesters plus link), the slave side
// is the scheduler itself.
interface bsg_link_upstream_sched_if #(
  parameter int els_p   = 4,
  parameter int width_p = 64
);

  logic [els_p-1:0]         req_valid_i;
  logic [els_p*width_p-1:0] req_data_i;
  logic [els_p-1:0]         req_last_i;
  logic [els_p-1:0]         req_ready_o;
  logic                     link_valid_o;
  logic [width_p-1:0]       link_data_o;
  logic                     link_ready_i;

  modport master (
    output req_valid_i,
    output req_data_i,
    output req_last_i,
    output link_ready_i,
    input  req_ready_o,
    input  link_valid_o,
    input  link_data_o
  );

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  req_last_i,
    input  link_ready_i,
    output req_ready_o,
    output link_valid_o,
    output link_data_o
  );

endinterface

// File: rtl/bsg_link_upstream_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// searching upward with wrap. Built as rotate, priority encode, un-rotate.
module bsg_link_rr_pick #(
  parameter int els_p = 4
) (
  input  logic [els_p-1:0]         req,
  input  logic [$clog2(els_p)-1:0] rr_ptr,
  output logic [$clog2(els_p)-1:0] grant,
  output logic                     any_valid
);

  localparam int ptr_w = $clog2(els_p);

  logic [2*els_p-1:0] doubled;
  logic [els_p-1:0]   rotated;
  logic [ptr_w-1:0]   offset;
  logic [ptr_w:0]     sum;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then rotate back
  always_comb begin
    doubled = {req, req};
    rotated = doubled[rr_ptr +: els_p];
    offset  = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (rotated[i]) offset = ptr_w'(i);
    end
    sum = {1'b0, offset} + {1'b0, rr_ptr};
    if (sum >= (ptr_w + 1)'(els_p)) sum = sum - (ptr_w + 1)'(els_p);
    grant     = sum[ptr_w-1:0];
    any_valid = |req;
  end

endmodule

// File: rtl/bsg_link_upstream_sched.sv
// Core-side scheduler sharing one link upstream port among els_p requesters.
// Round-robin between messages, locked to one requester for the length of a
// multi-flit message, with issue gated by a local credit counter.
module bsg_link_upstream_sched
  import bsg_link_sched_pkg::*;
#(
  parameter int els_p     = 4,
  parameter int width_p   = 64,
  parameter int credits_p = 16
) (
  input  logic                                core_clk_i,
  input  logic                                core_reset_n_i,
  bsg_link_upstream_sched_if.slave            io,
  input  logic                                credit_return_i,
  output logic [$clog2(els_p)-1:0]            grant_id_o,
  output logic [count_width(credits_p)-1:0]   credit_count_o,
  output logic                                busy_o,
  output logic                                error_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = count_width(credits_p);
  localparam logic [cnt_w-1:0] credits_full = cnt_w'(credits_p);

  sched_state_e     state_q, state_d;
  logic [ptr_w-1:0] rr_ptr_q, rr_ptr_d;
  logic [ptr_w-1:0] lock_q, lock_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic             error_q, error_d;

  logic [ptr_w-1:0] pick_grant;
  logic             any_valid;
  logic [ptr_w-1:0] grant;
  logic             have_credit;
  logic             transfer;
  logic             grant_last;

  // Step an index by one, wrapping at els_p (els_p need not be a power of 2)
  function automatic logic [ptr_w-1:0] wrap_inc(input logic [ptr_w-1:0] p);
    if (p == ptr_w'(els_p - 1)) return '0;
    return p + ptr_w'(1);
  endfunction

  bsg_link_rr_pick #(
    .els_p(els_p)
  ) rr_pick (
    .req      (io.req_valid_i),
    .rr_ptr   (rr_ptr_q),
    .grant    (pick_grant),
    .any_valid(any_valid)
  );

  // The lock owns the grant while a message is open; otherwise round-robin
  always_comb begin
    grant = rr_ptr_q;
    if (state_q == BUSY) grant = lock_q;
    else if (any_valid) grant = pick_grant;
  end

  // Zero-latency issue path; reset forces the handshake outputs quiet
  always_comb begin
    have_credit     = (count_q != '0);
    io.link_valid_o = core_reset_n_i & io.req_valid_i[grant] & have_credit;
    io.link_data_o  = io.req_data_i[grant*width_p +: width_p];
    io.req_ready_o  = '0;
    if (core_reset_n_i & io.link_ready_i & have_credit) io.req_ready_o[grant] = 1'b1;
    transfer   = core_reset_n_i & io.req_valid_i[grant] & have_credit & io.link_ready_i;
    grant_id_o = core_reset_n_i ? grant : '0;
  end

  // Next state, pointer, lock, credit and error values
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    count_d    = count_q;
    error_d    = error_q;
    grant_last = io.req_last_i[grant];
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (grant_last) begin
            rr_ptr_d = wrap_inc(grant);
          end else begin
            state_d = BUSY;
            lock_d  = grant;
          end
        end
      end
      BUSY: begin
        if (transfer && grant_last) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(lock_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (transfer && !credit_return_i) begin
      count_d = count_q - cnt_w'(1);
    end else if (!transfer && credit_return_i) begin
      if (count_q == credits_full) error_d = 1'b1;
      else count_d = count_q + cnt_w'(1);
    end
  end

  // FSM state register
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Pointer, lock, credit counter and sticky error registers
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      rr_ptr_q <= '0;
      lock_q   <= '0;
      count_q  <= credits_full;
      error_q  <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  assign busy_o         = (state_q == BUSY);
  assign credit_count_o = count_q;
  assign error_o        = error_q;

endmodule

// File: doc/bsg_link_upstream_sched.md
# bsg_link_upstream_sched

Core-side scheduler that shares one `bsg_link_ddr_upstream` core port among `els_p` requesters. It does round-robin, packet-locked arbitration and gates issue with a local credit counter, so a multi-flit message from one requester is never interleaved with another's. It sits in the core clock domain directly in front of the link's `core_valid_i/core_data_i/core_ready_o`.

## Interface
- `els_p`, 4: number of requesters (2..8).
- `width_p`, 64: flit width; equals the link `core_data_i` width.
- `credits_p`, 16: maximum flits outstanding toward the link before a return is required.
- `core_clk_i`  in  1: core clock; everything is on its rising edge.
- `core_reset_n_i`  in  1: one clock; reset is asynchronous and active-low.
- `req_valid_i`  in  els_p: per-requester flit valid.
- `req_data_i`  in  els_p*width_p: per-requester flit; requester i occupies bits [i*width_p +: width_p].
- `req_last_i`  in  els_p: flit is the last of its message.
- `req_ready_o`  out  els_p: flit accepted this cycle; asserted only for the granted requester.
- `link_valid_o`  out  1: to link `core_valid_i`.
- `link_data_o`  out  width_p: to link `core_data_i`.
- `link_ready_i`  in  1: from link `core_ready_o`.
- `credit_return_i`  in  1: one-cycle pulse that returns one credit. It is already synchronous to `core_clk_i`.
- `grant_id_o`  out  $clog2(els_p): current or locked grant index.
- `credit_count_o`  out  $clog2(credits_p+1): available credits.
- `busy_o`  out  1: a message is in progress (state BUSY).
- `error_o`  out  1: sticky flag, set when a credit is returned while the counter is full.

## Operation
- Transfer = `link_valid_o & link_ready_i`. On a transfer, the granted requester's flit is consumed and `req_ready_o[grant]` is high in that same cycle.
- State machine:
  - IDLE: the grant is the first valid requester at or after `rr_ptr`, searching upward and wrapping.
    - Transfer with `req_last_i` → stay IDLE; `rr_ptr` ← grant+1 (mod els_p).
    - Transfer without `req_last_i` → BUSY; lock register ← grant.
  - BUSY: the grant is the lock register only. Other requesters are ignored even when valid.
    - Transfer with last → IDLE; `rr_ptr` ← lock+1 (mod els_p).
- Issue rules:
  - `link_valid_o = req_valid_i[grant] & (credit_count != 0)`.
  - `link_data_o` = the granted slice. It is a don't-care when `link_valid_o` is low but must be driven: drive the granted slice.
  - `req_ready_o[grant] = link_ready_i & (credit_count != 0)`; the other bits of `req_ready_o` are 0.
- In IDLE with no valid requester: `grant_id_o = rr_ptr`.
- Credit counter:
  - Decrement on a transfer; increment on `credit_return_i`.
  - A transfer and a return in the same cycle leave the counter unchanged.
  - A return while the counter is at `credits_p` is dropped and sets `error_o`.
  - The counter never goes below 0, because issue is gated at 0.
- Credits at 0 in BUSY: the lock is held and the block waits. There is no timeout.
- Reset (async assert, mid-message included):
  - state IDLE, `rr_ptr` 0, lock 0, counter `credits_p`, `error_o` 0.
  - Outputs during reset: `busy_o` 0, `grant_id_o` 0, `credit_count_o` = `credits_p`, `link_valid_o` and `req_ready_o` 0.
  - A partial message is abandoned; the link-side reset is the owner's responsibility.

## Timing
- Zero-latency issue path: requester valid/data reach `link_*` combinationally in the same cycle.
- The path from `link_ready_i` to `req_ready_o` is combinational; there is no combinational path from `req_*` to `link_ready_i`.
- State, `rr_ptr`, lock, counter and `error_o` update on the edge after the event.
- `credit_count_o` and `busy_o` are registered.
- `grant_id_o` is combinational in IDLE and registered (the lock) in BUSY.
- Throughput: one flit per cycle while `link_ready_i` is high and credits are nonzero. Back-to-back single-flit messages from different requesters need no bubble.
- Reset deassertion must be synchronous to `core_clk_i`; the external synchronizer provides this.

## Structure
- Package `bsg_link_sched_pkg` holds:
  - the state enum `{IDLE, BUSY}`, 1 bit;
  - a localparam function for the counter width.
- Sub-module `bsg_link_rr_pick`: combinational.
  - Inputs: `els_p` request vector and `rr_ptr`.
  - Outputs: grant index and any-valid flag.
  - Implemented as a rotate, then priority encode, then un-rotate.
- Top level holds the FSM, the lock and pointer registers, the credit counter and the output mux.

## Test plan
- Reset, then all four requesters assert single-flit messages continuously with `link_ready_i`=1 → grants 0,1,2,3,0 on consecutive cycles; `credit_count_o` falls by 1 per cycle.
- Requester 1 sends a 3-flit message while 0 and 2 are valid → grants 1,1,1,2,0; `busy_o` is high for exactly the cycles after flits 1 and 2.
- `credits_p`=16 with no returns → 16 transfers, then `link_valid_o`=0 and `req_ready_o`=0. One `credit_return_i` pulse → exactly one more transfer.
- Transfer and `credit_return_i` in the same cycle at count 5 → count stays 5. A return at count 16 → count stays 16 and `error_o`=1 until reset.
- `link_ready_i` low for 3 cycles during a BUSY message → the lock is held, no `req_ready_o` is asserted, and the count is unchanged.
- Assert `core_reset_n_i` low asynchronously mid-message → outputs go to reset values immediately. After release, the first grant goes to the lowest-index valid requester.
